// File: rtl/dbg_guv_cmd_issuer.sv
// Head-of-chain command source for a dbg_guv daisy chain: buffers register-write
// requests in a small FIFO and emits 32-bit command words with an enforced idle
// gap, optionally following each batch with a latch command.
module dbg_guv_cmd_issuer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned AUTO_LATCH = 1,
  parameter int unsigned LATCH_REG  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_reg,
  input  logic [27-ADDR_WIDTH:0] req_val,
  input  logic                  req_TLAST,
  input  logic                  req_TVALID,
  output logic                  req_TREADY,
  output logic [31:0]           cmd_out_TDATA,
  output logic                  cmd_out_TVALID,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int unsigned VAL_WIDTH = 28 - ADDR_WIDTH;
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned CW        = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            rg;
    logic [VAL_WIDTH-1:0]  val;
    logic                  last;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EMIT, LATCH, GAP} state_t;

  entry_t                mem [DEPTH];
  entry_t                head;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  push, pop, resume;
  state_t                state, state_nxt;
  logic                  latch_pend, latch_pend_nxt;
  logic [CNT_W-1:0]      gap_cnt, gap_cnt_nxt;
  logic                  tvalid_c;
  logic [31:0]           tdata_c;

  assign push = req_TVALID && req_TREADY;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: req_addr, rg: req_reg, val: req_val, last: req_TLAST};
  end

  // FIFO pointers, occupancy, ready flag and the popped head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      req_TREADY <= 1'b0;
      head       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        head   <= mem[rd_ptr];
      end
      count      <= count_nxt;
      req_TREADY <= (count_nxt != CW'(DEPTH));
    end
  end

  // FSM state register with gap counter and pending-latch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      latch_pend <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      latch_pend <= latch_pend_nxt;
      gap_cnt    <= gap_cnt_nxt;
    end
  end

  // Next-state: 'resume' means behave as IDLE would (pop the next entry if any).
  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    resume         = 1'b0;
    latch_pend_nxt = latch_pend;
    gap_cnt_nxt    = (state == GAP) ? gap_cnt - CNT_W'(1) : gap_cnt;
    case (state)
      IDLE: resume = 1'b1;
      EMIT: begin
        if (head.last && (AUTO_LATCH != 0)) begin
          if (GAP_CYCLES != 0) begin
            state_nxt      = GAP;
            gap_cnt_nxt    = CNT_W'(GAP_CYCLES);
            latch_pend_nxt = 1'b1;
          end else begin
            state_nxt = LATCH;
          end
        end else if (GAP_CYCLES != 0) begin
          state_nxt   = GAP;
          gap_cnt_nxt = CNT_W'(GAP_CYCLES);
        end else begin
          resume = 1'b1;
        end
      end
      LATCH: begin
        if (GAP_CYCLES != 0) begin
          state_nxt   = GAP;
          gap_cnt_nxt = CNT_W'(GAP_CYCLES);
        end else begin
          resume = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt <= CNT_W'(1)) begin
          if (latch_pend) begin
            state_nxt      = LATCH;
            latch_pend_nxt = 1'b0;
          end else begin
            resume = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (resume) begin
      if (count != '0) begin
        pop       = 1'b1;
        state_nxt = EMIT;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Output decode: word to present on the next cycle.
  always_comb begin
    tvalid_c = (state == EMIT) || (state == LATCH);
    tdata_c  = cmd_out_TDATA;
    if (state == EMIT)  tdata_c = {head.addr, head.rg, head.val};
    if (state == LATCH) tdata_c = {head.addr, 4'(LATCH_REG), {VAL_WIDTH{1'b0}}};
  end

  // Registered outputs; TDATA holds its last word while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_out_TVALID <= 1'b0;
      cmd_out_TDATA  <= '0;
      words_sent     <= '0;
      busy           <= 1'b0;
    end else begin
      cmd_out_TVALID <= tvalid_c;
      if (tvalid_c) begin
        cmd_out_TDATA <= tdata_c;
        words_sent    <= words_sent + 16'd1;
      end
      busy <= (count_nxt != '0) || (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_dbg_guv_cmd_issuer.sv
// Bench for dbg_guv_cmd_issuer: two instances (no gap / gap of 2), a queue-based
// word-order model fed at request acceptance, and per-instance output monitors.
module tb_dbg_guv_cmd_issuer;

  localparam int unsigned GAP_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [11:0] a_addr, b_addr;
  logic [3:0]  a_reg, b_reg;
  logic [15:0] a_val, b_val;
  logic        a_last, b_last, a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_data, b_data;
  logic        a_tvalid, b_tvalid, a_busy, b_busy;
  logic [15:0] a_ws, b_ws;

  dbg_guv_cmd_issuer #(.ADDR_WIDTH(12), .DEPTH_LOG2(3), .GAP_CYCLES(0),
                       .AUTO_LATCH(1), .LATCH_REG(15)) dut_a (
    .clk(clk), .rst(rst_a), .req_addr(a_addr), .req_reg(a_reg), .req_val(a_val),
    .req_TLAST(a_last), .req_TVALID(a_valid), .req_TREADY(a_ready),
    .cmd_out_TDATA(a_data), .cmd_out_TVALID(a_tvalid), .busy(a_busy), .words_sent(a_ws));

  dbg_guv_cmd_issuer #(.ADDR_WIDTH(12), .DEPTH_LOG2(3), .GAP_CYCLES(GAP_B),
                       .AUTO_LATCH(1), .LATCH_REG(15)) dut_b (
    .clk(clk), .rst(rst_b), .req_addr(b_addr), .req_reg(b_reg), .req_val(b_val),
    .req_TLAST(b_last), .req_TVALID(b_valid), .req_TREADY(b_ready),
    .cmd_out_TDATA(b_data), .cmd_out_TVALID(b_tvalid), .busy(b_busy), .words_sent(b_ws));

  int checks = 0;
  int errors = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  int total_a = 0, total_b = 0;
  int cnt_a = 0, run_a = 0, max_run_a = 0;
  int cnt_b = 0, idle_b = 0, last_idle_b = 0, lows_b = 0;
  bit prev_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // Reference model: each accepted write yields its word, plus a latch word if last.
  function automatic void model_push(input int d, input logic [11:0] ad, input logic [3:0] rg,
                                     input logic [15:0] v, input logic last);
    logic [31:0] w, l;
    w = {ad, rg, v};
    l = {ad, 4'hF, 16'h0000};
    if (d == 0) begin
      q_a.push_back(w); total_a++;
      if (last) begin q_a.push_back(l); total_a++; end
    end else begin
      q_b.push_back(w); total_b++;
      if (last) begin q_b.push_back(l); total_b++; end
    end
  endfunction

  // Monitor A: word order, words_sent tally, length of back-to-back runs.
  always @(negedge clk) begin
    if (rst_a) begin
      cnt_a = 0; run_a = 0;
    end else if (a_tvalid) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_word actual=%h required=none", a_data);
      end else begin
        chk("a_word", a_data, q_a.pop_front());
      end
      cnt_a++;
      chk("a_words_sent", 32'(a_ws), 32'(cnt_a[15:0]));
      run_a++;
      if (run_a > max_run_a) max_run_a = run_a;
    end else begin
      run_a = 0;
    end
  end

  // Monitor B: word order, words_sent tally, minimum idle gap between words.
  always @(negedge clk) begin
    if (rst_b) begin
      cnt_b = 0; idle_b = 0; prev_b = 1'b0;
    end else if (b_tvalid) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_word actual=%h required=none", b_data);
      end else begin
        chk("b_word", b_data, q_b.pop_front());
      end
      cnt_b++;
      chk("b_words_sent", 32'(b_ws), 32'(cnt_b[15:0]));
      if (prev_b) chk("b_min_gap", 32'(idle_b >= int'(GAP_B)), 32'd1);
      last_idle_b = idle_b;
      idle_b      = 0;
      prev_b      = 1'b1;
    end else begin
      idle_b++;
    end
  end

  task automatic send(input int d, input logic [11:0] ad, input logic [3:0] rg,
                      input logic [15:0] v, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    if (d == 0) begin
      a_addr = ad; a_reg = rg; a_val = v; a_last = last; a_valid = 1'b1;
    end else begin
      b_addr = ad; b_reg = rg; b_val = v; b_last = last; b_valid = 1'b1;
    end
    while (!((d == 0) ? a_ready : b_ready)) begin
      if (d == 1) lows_b++;
      if (guard >= 300) begin
        fail_now("send_ready_timeout");
        if (d == 0) a_valid = 1'b0; else b_valid = 1'b0;
        return;
      end
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    model_push(d, ad, rg, v, last);
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    if (d == 0) a_valid = 1'b0; else b_valid = 1'b0;
  endtask

  task automatic drain(input int d, input int max_cycles);
    int g;
    g = 0;
    while (((d == 0) ? q_a.size() : q_b.size()) > 0 && g < max_cycles) begin
      @(negedge clk);
      g++;
    end
    if (((d == 0) ? q_a.size() : q_b.size()) > 0) fail_now("drain_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int g;
    {a_addr, a_reg, a_val, a_last, a_valid} = '0;
    {b_addr, b_reg, b_val, b_last, b_valid} = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_a_tvalid", 32'(a_tvalid), 0);
    chk("rst_a_tdata", a_data, 0);
    chk("rst_a_ws", 32'(a_ws), 0);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_tvalid", 32'(b_tvalid), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", 32'(a_ready), 1);
    chk("b_ready_after_rst", 32'(b_ready), 1);

    // No gap: three back-to-back writes come out on consecutive cycles
    max_run_a = 0;
    send(0, 12'h001, 4'h2, 16'h0010, 1'b0);
    send(0, 12'h001, 4'h2, 16'h0011, 1'b0);
    send(0, 12'h001, 4'h2, 16'h0012, 1'b0);
    idle(0);
    drain(0, 50);
    chk("a_back_to_back_run", 32'(max_run_a), 3);

    // Latency from acceptance on an idle instance
    send(1, 12'h0AB, 4'h1, 16'h1234, 1'b0);
    idle(1);
    chk("b_lat_edge_k", 32'(b_tvalid), 0);
    @(negedge clk);
    chk("b_lat_edge_k1", 32'(b_tvalid), 0);
    @(negedge clk);
    chk("b_lat_edge_k2", 32'(b_tvalid), 1);
    drain(1, 50);
    repeat (4) @(negedge clk);

    // Gap of 2 between two queued words
    send(1, 12'h010, 4'h3, 16'h0001, 1'b0);
    send(1, 12'h010, 4'h3, 16'h0002, 1'b0);
    idle(1);
    drain(1, 50);
    chk("b_gap_exact", 32'(last_idle_b), GAP_B);
    chk("b_ws_after_pair", 32'(b_ws), 32'(total_b));

    // Auto latch after a last write, itself preceded by the gap
    send(1, 12'h003, 4'h4, 16'h0005, 1'b1);
    idle(1);
    drain(1, 50);
    chk("b_latch_gap", 32'(last_idle_b), GAP_B);
    chk("b_ws_after_latch", 32'(b_ws), 32'(total_b));

    // Sustained requests: FIFO fills, backpressure, nothing lost or reordered
    lows_b = 0;
    for (int i = 0; i < 20; i++)
      send(1, 12'($urandom), 4'($urandom), 16'($urandom), 1'(($urandom % 4) == 0));
    idle(1);
    drain(1, 600);
    chk("b_backpressure_seen", 32'(lows_b > 0), 1);
    repeat (5) @(negedge clk);
    chk("b_busy_idle", 32'(b_busy), 0);

    // Reset while entries are pending and a word is on the wire
    for (int i = 0; i < 6; i++) send(1, 12'h050, 4'h5, 16'(i), 1'b0);
    idle(1);
    g = 0;
    while (!b_tvalid && g < 50) begin @(negedge clk); g++; end
    if (!b_tvalid) fail_now("b_wait_first_word");
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_mid_rst_tvalid", 32'(b_tvalid), 0);
    chk("b_mid_rst_busy", 32'(b_busy), 0);
    chk("b_mid_rst_ws", 32'(b_ws), 0);
    chk("b_mid_rst_tdata", b_data, 0);
    q_b.delete();
    total_b = 0;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (30) @(negedge clk);
    chk("b_no_words_after_rst", 32'(b_ws), 0);
    chk("b_ready_after_mid_rst", 32'(b_ready), 1);
    send(1, 12'h007, 4'h8, 16'h0009, 1'b1);
    idle(1);
    drain(1, 50);
    chk("b_ws_resume", 32'(b_ws), 32'(total_b));

    // words_sent wrap: push past 65536 words on the gapless instance
    for (int i = 0; i < 32770; i++)
      send(0, 12'($urandom), 4'($urandom), 16'($urandom), 1'b1);
    idle(0);
    drain(0, 100);
    chk("a_ws_wrapped", 32'(a_ws), 32'(total_a % 65536));

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
